// File: rtl/debug_link_pkg.sv
// Shared constants for the debug host link: command and reply bytes, dump status
// codes, controller state encoding and the dump serializer phase type.
package debug_link_pkg;

  localparam logic [7:0] CMD_LOAD  = 8'h4C;
  localparam logic [7:0] CMD_CLEAR = 8'h43;
  localparam logic [7:0] CMD_FLUSH = 8'h46;
  localparam logic [7:0] CMD_RUN   = 8'h52;
  localparam logic [7:0] CMD_STEP  = 8'h53;

  localparam logic [7:0] RSP_OK       = 8'h4B;
  localparam logic [7:0] RSP_LOAD_ERR = 8'hE1;
  localparam logic [7:0] RSP_BAD_CMD  = 8'hEE;

  localparam logic [7:0] STATUS_HALT    = 8'h00;
  localparam logic [7:0] STATUS_STEP    = 8'h01;
  localparam logic [7:0] STATUS_TIMEOUT = 8'h02;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_LOAD_CNT  = 4'd1;
  localparam logic [3:0] ST_LOAD_BYTE = 4'd2;
  localparam logic [3:0] ST_LOAD_WR   = 4'd3;
  localparam logic [3:0] ST_RUN       = 4'd4;
  localparam logic [3:0] ST_STEP      = 4'd5;
  localparam logic [3:0] ST_DUMP_ST   = 4'd6;
  localparam logic [3:0] ST_DUMP_W    = 4'd7;
  localparam logic [3:0] ST_DUMP_CS   = 4'd8;
  localparam logic [3:0] ST_REPLY     = 4'd9;
  localparam logic [3:0] ST_PULSE     = 4'd10;

  typedef enum logic [1:0] {SER_IDLE, SER_WORDS, SER_CS} ser_phase_t;

endpackage

// File: rtl/debug_host_link_if.sv
// Bundle of UART FIFO, instruction-memory and core-control signals seen by the
// debug host link; master is the link, slave is the FIFOs/core side.
interface debug_host_link_if #(
  parameter int WORD_BITS = 32,
  parameter int REG_COUNT = 32,
  parameter int MEM_WORDS = 32
);
  // Strobes uart_rd, uart_wr and ins_wr are single-cycle and transfer on the rising
  // edge where they are high; uart_rd is only raised while !uart_rx_empty (valid) and
  // uart_wr only while !uart_tx_full (ready), so a stalled byte simply holds.
  logic                           uart_rx_empty;
  logic [7:0]                     uart_rx_data;
  logic                           uart_rd;
  logic                           uart_tx_full;
  logic                           uart_wr;
  logic [7:0]                     uart_tx_data;
  logic                           imem_full;
  logic                           ins_wr;
  logic [WORD_BITS-1:0]           ins;
  logic                           mips_enable;
  logic                           mips_flush;
  logic                           mips_clear_prog;
  logic                           end_program;
  logic [WORD_BITS-1:0]           pc;
  logic [REG_COUNT*WORD_BITS-1:0] regs;
  logic [MEM_WORDS*WORD_BITS-1:0] mem;

  modport master (
    input  uart_rx_empty, uart_rx_data, uart_tx_full, imem_full, end_program, pc, regs, mem,
    output uart_rd, uart_wr, uart_tx_data, ins_wr, ins, mips_enable, mips_flush, mips_clear_prog
  );

  modport slave (
    output uart_rx_empty, uart_rx_data, uart_tx_full, imem_full, end_program, pc, regs, mem,
    input  uart_rd, uart_wr, uart_tx_data, ins_wr, ins, mips_enable, mips_flush, mips_clear_prog
  );
endinterface

// File: rtl/dump_serializer.sv
// Streams PC, registers and data memory MSB-first byte by byte, then the running XOR
// (seeded with the status byte) as a trailing checksum byte.
module dump_serializer
  import debug_link_pkg::*;
#(
  parameter int WORD_BITS = 32,
  parameter int REG_COUNT = 32,
  parameter int MEM_WORDS = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [7:0]                     seed,
  input  logic                           tx_full,
  input  logic [WORD_BITS-1:0]           pc,
  input  logic [REG_COUNT*WORD_BITS-1:0] regs,
  input  logic [MEM_WORDS*WORD_BITS-1:0] mem,
  output logic                           busy,
  output logic                           wr,
  output logic [7:0]                     tx_data,
  output logic                           last_word_byte,
  output logic                           done
);
  localparam int N_WORDS = 1 + REG_COUNT + MEM_WORDS;
  localparam int BPW     = WORD_BITS / 8;
  localparam int WI_W    = $clog2(N_WORDS);
  localparam int BI_W    = (BPW > 1) ? $clog2(BPW) : 1;

  ser_phase_t                   phase;
  logic [WI_W-1:0]              word_idx;
  logic [BI_W-1:0]              byte_idx;
  logic [7:0]                   xor_acc;
  logic [N_WORDS*WORD_BITS-1:0] flat;
  logic [WORD_BITS-1:0]         words [N_WORDS];
  logic [WORD_BITS-1:0]         cur_word;
  logic [7:0]                   word_bytes [BPW];
  logic [7:0]                   cur_byte;
  logic                         byte_last;
  logic                         word_last;

  assign flat = {mem, regs, pc};

  for (genvar w = 0; w < N_WORDS; w++) begin : g_words
    assign words[w] = flat[w*WORD_BITS +: WORD_BITS];
  end

  assign cur_word = words[word_idx];

  // Byte 0 of a word is its most significant byte.
  for (genvar b = 0; b < BPW; b++) begin : g_bytes
    assign word_bytes[b] = cur_word[WORD_BITS-1-8*b -: 8];
  end

  assign cur_byte       = word_bytes[byte_idx];
  assign byte_last      = byte_idx == BI_W'(BPW - 1);
  assign word_last      = word_idx == WI_W'(N_WORDS - 1);
  assign busy           = phase != SER_IDLE;
  assign wr             = busy && !tx_full;
  assign tx_data        = (phase == SER_CS) ? xor_acc : cur_byte;
  assign last_word_byte = (phase == SER_WORDS) && !tx_full && byte_last && word_last;
  assign done           = (phase == SER_CS) && !tx_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= SER_IDLE;
      word_idx <= '0;
      byte_idx <= '0;
      xor_acc  <= '0;
    end else begin
      case (phase)
        SER_IDLE: if (start) begin
          phase    <= SER_WORDS;
          word_idx <= '0;
          byte_idx <= '0;
          xor_acc  <= seed;
        end
        SER_WORDS: if (!tx_full) begin
          xor_acc <= xor_acc ^ cur_byte;
          if (byte_last) begin
            byte_idx <= '0;
            if (word_last) begin
              word_idx <= '0;
              phase    <= SER_CS;
            end else begin
              word_idx <= word_idx + WI_W'(1);
            end
          end else begin
            byte_idx <= byte_idx + BI_W'(1);
          end
        end
        SER_CS: if (!tx_full) phase <= SER_IDLE;
        default: phase <= SER_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/debug_host_link.sv
// Host-side debug controller: decodes UART command bytes into program load, clear,
// flush, run and single step, then hands the state dump to dump_serializer.
module debug_host_link
  import debug_link_pkg::*;
#(
  parameter int WORD_BITS    = 32,
  parameter int REG_COUNT    = 32,
  parameter int MEM_WORDS    = 32,
  parameter int RUN_TIMEOUT  = 2**20,
  parameter int TIMEOUT_BITS = 21
) (
  input  logic               i_clk,
  input  logic               i_reset,
  debug_host_link_if.master  bus,
  output logic [3:0]         o_state
);
  localparam int BPW  = WORD_BITS / 8;
  localparam int BI_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [TIMEOUT_BITS-1:0] RUN_LIMIT = TIMEOUT_BITS'(RUN_TIMEOUT);

  logic [3:0]              state;
  logic [7:0]              reply_byte;
  logic [7:0]              status;
  logic [8:0]              load_left;
  logic [BI_W-1:0]         byte_idx;
  logic [WORD_BITS-1:0]    ins_buf;
  logic                    load_err;
  logic                    pulse_clear;
  logic [TIMEOUT_BITS-1:0] run_cnt;
  logic                    rx_pop;
  logic                    run_timeout;
  logic                    ser_start;
  logic                    ser_busy;
  logic                    ser_wr;
  logic [7:0]              ser_data;
  logic                    ser_last;
  logic                    ser_done;

  assign rx_pop = !bus.uart_rx_empty &&
                  (state == ST_IDLE || state == ST_LOAD_CNT || state == ST_LOAD_BYTE);
  assign run_timeout = run_cnt == RUN_LIMIT;
  assign ser_start   = (state == ST_DUMP_ST) && !bus.uart_tx_full && !ser_busy;

  assign bus.uart_rd         = rx_pop;
  assign bus.ins_wr          = (state == ST_LOAD_WR) && !bus.imem_full;
  assign bus.ins             = ins_buf;
  assign bus.mips_enable     = ((state == ST_RUN) && !bus.end_program && !run_timeout) ||
                               ((state == ST_STEP) && !bus.end_program);
  assign bus.mips_flush      = (state == ST_PULSE) && !pulse_clear;
  assign bus.mips_clear_prog = (state == ST_PULSE) && pulse_clear;
  assign o_state             = state;

  always_comb begin
    bus.uart_wr      = 1'b0;
    bus.uart_tx_data = 8'h00;
    case (state)
      ST_REPLY: begin
        bus.uart_wr      = !bus.uart_tx_full;
        bus.uart_tx_data = reply_byte;
      end
      ST_DUMP_ST: begin
        bus.uart_wr      = !bus.uart_tx_full;
        bus.uart_tx_data = status;
      end
      ST_DUMP_W, ST_DUMP_CS: begin
        bus.uart_wr      = ser_wr;
        bus.uart_tx_data = ser_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state       <= ST_IDLE;
      reply_byte  <= '0;
      status      <= '0;
      load_left   <= '0;
      byte_idx    <= '0;
      ins_buf     <= '0;
      load_err    <= 1'b0;
      pulse_clear <= 1'b0;
      run_cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: if (rx_pop) begin
          case (bus.uart_rx_data)
            CMD_LOAD:  state <= ST_LOAD_CNT;
            CMD_CLEAR: begin pulse_clear <= 1'b1; state <= ST_PULSE; end
            CMD_FLUSH: begin pulse_clear <= 1'b0; state <= ST_PULSE; end
            CMD_RUN:   begin run_cnt <= '0; state <= ST_RUN; end
            CMD_STEP:  state <= ST_STEP;
            default:   begin reply_byte <= RSP_BAD_CMD; state <= ST_REPLY; end
          endcase
        end
        ST_LOAD_CNT: if (rx_pop) begin
          load_left <= (bus.uart_rx_data == 8'd0) ? 9'd256 : {1'b0, bus.uart_rx_data};
          byte_idx  <= '0;
          load_err  <= 1'b0;
          state     <= ST_LOAD_BYTE;
        end
        ST_LOAD_BYTE: if (rx_pop) begin
          ins_buf <= (ins_buf << 8) | WORD_BITS'(bus.uart_rx_data);
          if (byte_idx == BI_W'(BPW - 1)) state <= ST_LOAD_WR;
          else byte_idx <= byte_idx + BI_W'(1);
        end
        // A word refused by a full memory is dropped, but its bytes were still consumed.
        ST_LOAD_WR: begin
          byte_idx  <= '0;
          load_left <= load_left - 9'd1;
          if (bus.imem_full) load_err <= 1'b1;
          if (load_left == 9'd1) begin
            reply_byte <= (load_err || bus.imem_full) ? RSP_LOAD_ERR : RSP_OK;
            state      <= ST_REPLY;
          end else begin
            state <= ST_LOAD_BYTE;
          end
        end
        // The counter stops at RUN_LIMIT because the run is abandoned there.
        ST_RUN: begin
          if (bus.end_program) begin
            status <= STATUS_HALT;
            state  <= ST_DUMP_ST;
          end else if (run_timeout) begin
            status <= STATUS_TIMEOUT;
            state  <= ST_DUMP_ST;
          end else begin
            run_cnt <= run_cnt + TIMEOUT_BITS'(1);
          end
        end
        ST_STEP: begin
          status <= bus.end_program ? STATUS_HALT : STATUS_STEP;
          state  <= ST_DUMP_ST;
        end
        ST_DUMP_ST: if (ser_start) state <= ST_DUMP_W;
        ST_DUMP_W:  if (ser_last) state <= ST_DUMP_CS;
        ST_DUMP_CS: if (ser_done) state <= ST_IDLE;
        ST_REPLY:   if (!bus.uart_tx_full) state <= ST_IDLE;
        ST_PULSE: begin
          reply_byte <= RSP_OK;
          state      <= ST_REPLY;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  dump_serializer #(
    .WORD_BITS(WORD_BITS),
    .REG_COUNT(REG_COUNT),
    .MEM_WORDS(MEM_WORDS)
  ) u_dump (
    .clk            (i_clk),
    .rst_n          (i_reset),
    .start          (ser_start),
    .seed           (status),
    .tx_full        (bus.uart_tx_full),
    .pc             (bus.pc),
    .regs           (bus.regs),
    .mem            (bus.mem),
    .busy           (ser_busy),
    .wr             (ser_wr),
    .tx_data        (ser_data),
    .last_word_byte (ser_last),
    .done           (ser_done)
  );

endmodule

// File: tb/tb_debug_host_link.sv
// Scoreboard bench for debug_host_link: models the RX/TX FIFOs and core state,
// predicts every TX byte and instruction write, and counts core-enable cycles.
module tb_debug_host_link;

  localparam int WORD_BITS    = 32;
  localparam int REG_COUNT    = 32;
  localparam int MEM_WORDS    = 32;
  localparam int RUN_TIMEOUT  = 16;
  localparam int TIMEOUT_BITS = 5;
  localparam int N_WORDS      = 1 + REG_COUNT + MEM_WORDS;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] dut_state;

  always #5 clk = ~clk;

  debug_host_link_if #(.WORD_BITS(WORD_BITS), .REG_COUNT(REG_COUNT), .MEM_WORDS(MEM_WORDS)) bus ();

  debug_host_link #(
    .WORD_BITS(WORD_BITS), .REG_COUNT(REG_COUNT), .MEM_WORDS(MEM_WORDS),
    .RUN_TIMEOUT(RUN_TIMEOUT), .TIMEOUT_BITS(TIMEOUT_BITS)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus),
    .o_state (dut_state)
  );

  logic [7:0]  exp_q[$];
  logic [31:0] ins_exp_q[$];
  logic [7:0]  rx_q[$];
  logic [31:0] pc_m;
  logic [31:0] regs_m [REG_COUNT];
  logic [31:0] mem_m [MEM_WORDS];
  logic        pop_now = 1'b0;
  int n_checks = 0, n_pass = 0;
  int cyc = 0, stall_until = 0, stall_seen = 0, wr_while_full = 0;
  int en_cnt = 0, flush_cnt = 0, clear_cnt = 0, ins_cnt = 0, tx_cnt = 0, pop_cnt = 0;
  int unexp_tx = 0, unexp_ins = 0;
  int base_en, base_ins, base_pop, base_tx, base_flush, base_clear, base_stall;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Cycle start: apply last cycle's pop, drive FIFO flags. Tests may change inputs next.
  task automatic cyc_begin();
    @(negedge clk);
    cyc++;
    if (pop_now && rx_q.size() > 0) rx_q.delete(0);
    bus.uart_rx_empty = (rx_q.size() == 0);
    bus.uart_rx_data  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    bus.uart_tx_full  = (cyc < stall_until);
    if (bus.uart_tx_full) stall_seen++;
  endtask

  // Cycle end: sample what the DUT commits at the coming rising edge.
  task automatic cyc_end();
    logic [7:0]  eb;
    logic [31:0] ew;
    #1;
    pop_now = rst_n && bus.uart_rd;
    if (!rst_n) return;
    if (pop_now) pop_cnt++;
    if (bus.uart_wr) begin
      tx_cnt++;
      if (bus.uart_tx_full) wr_while_full++;
      if (exp_q.size() == 0) unexp_tx++;
      else begin
        eb = exp_q.pop_front();
        check_val("tx_byte", {24'h0, bus.uart_tx_data}, {24'h0, eb});
      end
    end
    if (bus.ins_wr) begin
      ins_cnt++;
      if (ins_exp_q.size() == 0) unexp_ins++;
      else begin
        ew = ins_exp_q.pop_front();
        check_val("ins_word", bus.ins, ew);
      end
    end
    if (bus.mips_enable) en_cnt++;
    if (bus.mips_flush) flush_cnt++;
    if (bus.mips_clear_prog) clear_cnt++;
  endtask

  task automatic tick();
    cyc_begin();
    cyc_end();
  endtask

  task automatic wait_done(input string tag);
    int i;
    for (i = 0; i < 3000; i++) begin
      if (rx_q.size() == 0 && exp_q.size() == 0 && ins_exp_q.size() == 0 && dut_state == 4'd0)
        break;
      tick();
    end
    check_val({tag, "_done"}, {31'h0, i < 3000}, 32'h1);
  endtask

  task automatic mark();
    base_en = en_cnt; base_ins = ins_cnt; base_pop = pop_cnt; base_tx = tx_cnt;
    base_flush = flush_cnt; base_clear = clear_cnt; base_stall = stall_seen;
  endtask

  task automatic set_core();
    pc_m = $urandom;
    bus.pc = pc_m;
    for (int i = 0; i < REG_COUNT; i++) begin
      regs_m[i] = $urandom;
      bus.regs[i*32 +: 32] = regs_m[i];
    end
    for (int i = 0; i < MEM_WORDS; i++) begin
      mem_m[i] = $urandom_range(0, 32'hFFFF) ^ (i << 20);
      bus.mem[i*32 +: 32] = mem_m[i];
    end
  endtask

  task automatic push_dump(input logic [7:0] st);
    logic [7:0]  x;
    logic [31:0] w;
    x = st;
    exp_q.push_back(st);
    for (int k = 0; k < N_WORDS; k++) begin
      if (k == 0) w = pc_m;
      else if (k <= REG_COUNT) w = regs_m[k-1];
      else w = mem_m[k-1-REG_COUNT];
      for (int j = 3; j >= 0; j--) begin
        exp_q.push_back(w[j*8 +: 8]);
        x = x ^ w[j*8 +: 8];
      end
    end
    exp_q.push_back(x);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_rd"},    {31'h0, bus.uart_rd}, 32'h0);
    check_val({tag, "_wr"},    {31'h0, bus.uart_wr}, 32'h0);
    check_val({tag, "_txd"},   {24'h0, bus.uart_tx_data}, 32'h0);
    check_val({tag, "_inswr"}, {31'h0, bus.ins_wr}, 32'h0);
    check_val({tag, "_ins"},   bus.ins, 32'h0);
    check_val({tag, "_en"},    {31'h0, bus.mips_enable}, 32'h0);
    check_val({tag, "_flush"}, {31'h0, bus.mips_flush}, 32'h0);
    check_val({tag, "_clear"}, {31'h0, bus.mips_clear_prog}, 32'h0);
    check_val({tag, "_state"}, {28'h0, dut_state}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.uart_rx_empty = 1'b1; bus.uart_rx_data = '0; bus.uart_tx_full = 1'b0;
    bus.imem_full = 1'b0; bus.end_program = 1'b0;
    bus.pc = '0; bus.regs = '0; bus.mem = '0;

    // Reset state
    repeat (3) tick();
    check_idle_outputs("reset");
    cyc_begin(); rst_n = 1'b1; cyc_end();

    // Two-word program load
    mark();
    rx_q = '{8'h4C, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    ins_exp_q.push_back(32'h0000_0001);
    ins_exp_q.push_back(32'hAABB_CCDD);
    exp_q.push_back(8'h4B);
    wait_done("load2");
    check_val("load2_ins_cnt", ins_cnt - base_ins, 2);
    check_val("load2_pops", pop_cnt - base_pop, 10);

    // Load into a full instruction memory: bytes consumed, word dropped
    mark();
    bus.imem_full = 1'b1;
    rx_q = '{8'h4C, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    exp_q.push_back(8'hE1);
    wait_done("loadfull");
    bus.imem_full = 1'b0;
    check_val("loadfull_ins_cnt", ins_cnt - base_ins, 0);
    check_val("loadfull_pops", pop_cnt - base_pop, 6);

    // Unknown command, flush, clear
    rx_q.push_back(8'h7A); exp_q.push_back(8'hEE);
    wait_done("unknown");
    mark();
    rx_q.push_back(8'h46); exp_q.push_back(8'h4B);
    wait_done("flush");
    check_val("flush_pulses", flush_cnt - base_flush, 1);
    mark();
    rx_q.push_back(8'h43); exp_q.push_back(8'h4B);
    wait_done("clear");
    check_val("clear_pulses", clear_cnt - base_clear, 1);
    check_val("clear_no_flush", flush_cnt - base_flush, 0);

    // Run until the core halts after 10 enabled cycles
    mark();
    set_core();
    rx_q.push_back(8'h52);
    push_dump(8'h00);
    for (int i = 0; i < 200 && en_cnt - base_en < 10; i++) tick();
    cyc_begin(); bus.end_program = 1'b1; cyc_end();
    wait_done("run_halt");
    bus.end_program = 1'b0;
    check_val("run_halt_en", en_cnt - base_en, 10);
    check_val("run_halt_bytes", tx_cnt - base_tx, 262);

    // Single step
    mark();
    set_core();
    rx_q.push_back(8'h53);
    push_dump(8'h01);
    wait_done("step");
    check_val("step_en", en_cnt - base_en, 1);

    // Step with the core already halted: no enable, halt status
    mark();
    set_core();
    bus.end_program = 1'b1;
    rx_q.push_back(8'h53);
    push_dump(8'h00);
    wait_done("step_halted");
    bus.end_program = 1'b0;
    check_val("step_halted_en", en_cnt - base_en, 0);

    // Run without halt hits the timeout
    mark();
    set_core();
    rx_q.push_back(8'h52);
    push_dump(8'h02);
    wait_done("run_timeout");
    check_val("run_timeout_en", en_cnt - base_en, RUN_TIMEOUT);

    // TX FIFO full for 50 cycles in the middle of a dump
    mark();
    set_core();
    rx_q.push_back(8'h53);
    push_dump(8'h01);
    for (int i = 0; i < 500 && exp_q.size() > 150; i++) tick();
    stall_until = cyc + 51;
    wait_done("stall");
    check_val("stall_cycles", stall_seen - base_stall, 50);
    check_val("stall_wr_while_full", wr_while_full, 0);
    check_val("stall_bytes", tx_cnt - base_tx, 262);

    // Reset in the middle of a load, then a normal clear
    mark();
    rx_q = '{8'h4C, 8'h01, 8'h12, 8'h34};
    for (int i = 0; i < 50 && rx_q.size() > 0; i++) tick();
    repeat (2) tick();
    check_val("midload_state", {28'h0, dut_state}, 32'h2);
    cyc_begin(); rst_n = 1'b0; cyc_end();
    check_idle_outputs("midload_reset");
    tick();
    cyc_begin(); rst_n = 1'b1; cyc_end();
    check_val("midload_no_write", ins_cnt - base_ins, 0);
    rx_q.push_back(8'h43); exp_q.push_back(8'h4B);
    wait_done("post_reset_clear");
    check_val("post_reset_clear_pulses", clear_cnt - base_clear, 1);

    check_val("unexpected_tx", unexp_tx, 0);
    check_val("unexpected_ins", unexp_ins, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
